// File: rtl/game_pkg.sv
// Shared game-phase encoding, score width and seven-segment glyphs
// (active-low, bit0 = segment a .. bit6 = segment g).
package game_pkg;

  localparam int unsigned SCORE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2,
    ST_WIN  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_I     = 7'b1111001;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage

// File: rtl/seven_seg_decoder.sv
// Decimal digit to active-low seven-segment pattern; values 10..15 blank.
module seven_seg_decoder
  import game_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_val)
      4'd0: o_seg = SEG_ZERO;
      4'd1: o_seg = 7'b1111001;
      4'd2: o_seg = 7'b0100100;
      4'd3: o_seg = 7'b0110000;
      4'd4: o_seg = 7'b0011001;
      4'd5: o_seg = 7'b0010010;
      4'd6: o_seg = 7'b0000010;
      4'd7: o_seg = 7'b1111000;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0010000;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/high_score_display.sv
// Game-phase tracker holding the best score since reset; shows it on HEX1:HEX0
// (blinking after a new record) and a status word on HEX5:HEX4.
module high_score_display
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BLINK_HZ  = 2,
  parameter int unsigned MAX_SCORE = 99
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               run,
  input  logic               game_over,
  input  logic               win,
  input  logic [SCORE_W-1:0] score,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX4,
  output logic [6:0]         HEX5,
  output logic               new_record
);

  localparam int unsigned HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(HALF - 1);
  localparam logic [SCORE_W-1:0] MAX_S   = SCORE_W'(MAX_SCORE);

  state_t             r_state;
  logic [SCORE_W-1:0] r_hi;
  logic               r_new_record;
  logic               r_run_d;
  logic               r_win_d;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_blank;

  logic               w_run_rise;
  logic               w_win_rise;
  logic               w_restart;
  logic [SCORE_W-1:0] w_s;
  logic [3:0]         w_tens;
  logic [3:0]         w_ones;
  logic [6:0]         w_tens_seg;
  logic [6:0]         w_ones_seg;

  assign w_run_rise = run & ~r_run_d;
  assign w_win_rise = win & ~r_win_d;
  assign w_restart  = w_run_rise && ((r_state == ST_OVER) || (r_state == ST_WIN));
  assign w_s        = (score > MAX_S) ? MAX_S : score;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_hi         <= '0;
      r_new_record <= 1'b0;
      r_run_d      <= 1'b0;
      r_win_d      <= 1'b0;
    end else begin
      r_run_d <= run;
      r_win_d <= win;
      case (r_state)
        ST_IDLE: if (w_run_rise) r_state <= ST_PLAY;
        ST_PLAY: begin
          // win outranks a simultaneous collision; both capture the score
          if (w_win_rise || game_over) begin
            r_state <= w_win_rise ? ST_WIN : ST_OVER;
            if (w_s > r_hi) begin
              r_hi         <= w_s;
              r_new_record <= 1'b1;
            end
          end else if (!run) begin
            r_state <= ST_IDLE;
          end
        end
        ST_OVER, ST_WIN: begin
          if (w_run_rise) begin
            r_state      <= ST_PLAY;
            r_new_record <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_blank <= 1'b0;
    end else if (!r_new_record || w_restart) begin
      r_cnt   <= '0;
      r_blank <= 1'b0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt   <= '0;
      r_blank <= ~r_blank;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_tens = 4'(r_hi / SCORE_W'(10));
  assign w_ones = 4'(r_hi % SCORE_W'(10));

  seven_seg_decoder u_tens (.i_val(w_tens), .o_seg(w_tens_seg));
  seven_seg_decoder u_ones (.i_val(w_ones), .o_seg(w_ones_seg));

  assign HEX1       = r_blank ? SEG_BLANK : w_tens_seg;
  assign HEX0       = r_blank ? SEG_BLANK : w_ones_seg;
  assign new_record = r_new_record;

  always_comb begin
    HEX5 = SEG_BLANK;
    HEX4 = SEG_BLANK;
    case (r_state)
      ST_PLAY: begin HEX5 = SEG_DASH; HEX4 = SEG_DASH; end
      ST_OVER: begin HEX5 = SEG_L;    HEX4 = SEG_O;    end
      ST_WIN:  begin HEX5 = SEG_H;    HEX4 = SEG_I;    end
      default: begin HEX5 = SEG_BLANK; HEX4 = SEG_BLANK; end
    endcase
  end

endmodule

// File: tb/tb_high_score_display.sv
// Directed scenarios for high_score_display with a fast blink (toggle every 4 cycles).
module tb_high_score_display;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D9 = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] GL = 7'b1000111;
  localparam logic [6:0] GO = 7'b0100011;
  localparam logic [6:0] GH = 7'b0001001;
  localparam logic [6:0] GI = 7'b1111001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       game_over = 1'b0;
  logic       win = 1'b0;
  logic [7:0] score = 8'd0;
  logic [6:0] HEX0, HEX1, HEX4, HEX5;
  logic       new_record;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  high_score_display #(.CLK_HZ(8), .BLINK_HZ(1), .MAX_SCORE(99)) dut (
    .CLOCK_50(clk), .reset(reset), .run(run), .game_over(game_over), .win(win),
    .score(score), .HEX0(HEX0), .HEX1(HEX1), .HEX4(HEX4), .HEX5(HEX5),
    .new_record(new_record)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    run = 1'b0; tick();
    run = 1'b1; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({HEX1, HEX0, HEX5, HEX4, new_record} !== {D0, D0, BL, BL, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_idle: got %b %b %b %b nr=%b want %b %b %b %b nr=0",
               HEX1, HEX0, HEX5, HEX4, new_record, D0, D0, BL, BL);
    end
  endtask

  task automatic test_record_blink();
    logic exp_blank;
    score = 8'd37;
    start_game();
    n_cmp++;
    if ({HEX5, HEX4} !== {DASH, DASH}) begin
      n_bad++; $display("FAIL play_status: got %b %b want %b %b", HEX5, HEX4, DASH, DASH);
    end
    game_over = 1'b1; tick(); game_over = 1'b0;
    n_cmp++;
    if ({HEX1, HEX0, HEX5, HEX4, new_record} !== {D3, D7, GL, GO, 1'b1}) begin
      n_bad++;
      $display("FAIL record37: got %b %b %b %b nr=%b want %b %b %b %b nr=1",
               HEX1, HEX0, HEX5, HEX4, new_record, D3, D7, GL, GO);
    end
    for (int k = 2; k <= 12; k++) begin
      tick();
      exp_blank = (k >= 5) && (k <= 8);
      n_cmp++;
      if ({HEX1, HEX0} !== (exp_blank ? {BL, BL} : {D3, D7})) begin
        n_bad++;
        $display("FAIL blink_cycle%0d: got %b %b want blank=%b", k, HEX1, HEX0, exp_blank);
      end
    end
  endtask

  task automatic test_no_record(input logic [7:0] sc);
    score = sc;
    start_game();
    n_cmp++;
    if (new_record !== 1'b0) begin
      n_bad++; $display("FAIL restart_clear_%0d: got nr=%b want 0", sc, new_record);
    end
    game_over = 1'b1; tick(); game_over = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      n_cmp++;
      if ({HEX1, HEX0, HEX5, HEX4, new_record} !== {D3, D7, GL, GO, 1'b0}) begin
        n_bad++;
        $display("FAIL norecord_%0d_c%0d: got %b %b %b %b nr=%b want %b %b %b %b nr=0",
                 sc, k, HEX1, HEX0, HEX5, HEX4, new_record, D3, D7, GL, GO);
      end
      tick();
    end
  endtask

  task automatic test_abort_and_idle_pulse();
    score = 8'd80;
    start_game();
    run = 1'b0; tick();
    n_cmp++;
    if ({HEX1, HEX0, HEX5, HEX4, new_record} !== {D3, D7, BL, BL, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_idle: got %b %b %b %b nr=%b want %b %b %b %b nr=0",
               HEX1, HEX0, HEX5, HEX4, new_record, D3, D7, BL, BL);
    end
    game_over = 1'b1; tick(); game_over = 1'b0; tick();
    n_cmp++;
    if ({HEX1, HEX0, HEX5, HEX4, new_record} !== {D3, D7, BL, BL, 1'b0}) begin
      n_bad++;
      $display("FAIL idle_gameover_ignored: got %b %b %b %b nr=%b want %b %b %b %b nr=0",
               HEX1, HEX0, HEX5, HEX4, new_record, D3, D7, BL, BL);
    end
  endtask

  task automatic test_win_clamp();
    score = 8'd150;
    start_game();
    win = 1'b1; game_over = 1'b1; tick(); game_over = 1'b0;
    n_cmp++;
    if ({HEX1, HEX0, HEX5, HEX4, new_record} !== {D9, D9, GH, GI, 1'b1}) begin
      n_bad++;
      $display("FAIL win_clamp: got %b %b %b %b nr=%b want %b %b %b %b nr=1",
               HEX1, HEX0, HEX5, HEX4, new_record, D9, D9, GH, GI);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 2; k <= 5; k++) tick();
    n_cmp++;
    if ({HEX1, HEX0} !== {BL, BL}) begin
      n_bad++; $display("FAIL preblink: got %b %b want blank", HEX1, HEX0);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({HEX1, HEX0, HEX5, HEX4, new_record} !== {D0, D0, BL, BL, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got %b %b %b %b nr=%b want %b %b %b %b nr=0",
               HEX1, HEX0, HEX5, HEX4, new_record, D0, D0, BL, BL);
    end
    win = 1'b0; run = 1'b0; score = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({HEX1, HEX0, HEX5, HEX4, new_record} !== {D0, D0, BL, BL, 1'b0}) begin
      n_bad++;
      $display("FAIL post_reset: got %b %b %b %b nr=%b want %b %b %b %b nr=0",
               HEX1, HEX0, HEX5, HEX4, new_record, D0, D0, BL, BL);
    end
  endtask

  initial begin
    test_reset();
    test_record_blink();
    test_no_record(8'd20);
    test_no_record(8'd37);
    test_abort_and_idle_pulse();
    test_win_clamp();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/high_score_display.md
Name: high_score_display

Overview:
- Downstream consumer of the per-second score counter, which produces a 0..99 count and a "reached 99" win flag.
- Tracks game phase (idle / playing / over / won) and holds the best score since reset.
- Shows the best score as two decimal digits on HEX1:HEX0, blinking when a new record is set.
- Shows a two-glyph status word on HEX5:HEX4.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
BLINK_HZ, 2, full blink cycles per second for the new-record blink
MAX_SCORE, 99, clamp ceiling for the incoming score

Ports:
CLOCK_50  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  level, high while a game is in progress (from game controller)
game_over  input  1  one-cycle pulse on collision
win  input  1  level win flag from score counter (sticky until counter reset)
score  input  8  current score, binary, nominally 0..99
HEX0  output  7  best-score ones digit, active-low, bit0=seg a .. bit6=seg g
HEX1  output  7  best-score tens digit, same encoding
HEX4  output  7  status glyph, right
HEX5  output  7  status glyph, left
new_record  output  1  high from a record capture until next game start

Behaviour:
- Reset (async, immediate):
  - state=IDLE, hi_score=0, new_record=0, blink counter=0, blank_phase=0, run_d=0, win_d=0.
  - Resulting outputs: HEX1=HEX0=7'b1000000 ("0"); HEX5=HEX4=7'b1111111 (blank).
- Edge detect: run_rise = run & ~run_d; win_rise = win & ~win_d. run_d and win_d are registered every cycle.
- Clamp: s = (score > MAX_SCORE) ? MAX_SCORE : score, combinational.
- States and transitions:
  - IDLE: on run_rise -> PLAY.
  - PLAY: priority win_rise > game_over > ~run.
    - win_rise: capture, then -> WIN.
    - game_over: capture, then -> OVER.
    - run low with no event: -> IDLE, no capture.
  - OVER / WIN: on run_rise -> PLAY; clear new_record, blink counter and blank_phase.
- Capture, same edge as the state change:
  - if s > hi_score: hi_score<=s, new_record<=1.
  - Equal score is not a record.
  - hi_score is visible on HEX the cycle after the event.
- game_over or win_rise outside PLAY: ignored.
- Blink:
  - While new_record=1, the counter counts to CLK_HZ/(2*BLINK_HZ)-1, wraps to 0 and toggles blank_phase.
  - blank_phase=1 forces HEX1=HEX0=7'b1111111.
  - new_record=0 holds counter=0 and blank_phase=0.
- Digits: tens=hi_score/10, ones=hi_score%10, combinational from the registered hi_score. Leading zero is shown (e.g. "07").
- Status glyphs (HEX5,HEX4), combinational from state:
  - IDLE = blank, blank.
  - PLAY = "-" 7'b0111111, "-".
  - OVER = "L" 7'b1000111, "o" 7'b0100011.
  - WIN = "H" 7'b0001001, "I" 7'b1111001.
- Latency:
  - Status glyphs follow the state register (1 cycle after the triggering edge).
  - No other output pipeline.
- Reset mid-game: returns to IDLE; hi_score is lost. Best score is volatile by design.

Decomposition:
- Shared package (game_pkg):
  - state encoding IDLE/PLAY/OVER/WIN (2 bits);
  - glyph constants SEG_BLANK, SEG_DASH, SEG_L, SEG_O, SEG_H, SEG_I, SEG_ZERO;
  - score width 8.
- One sub-module: seven_seg_decoder (4-bit value -> 7-bit active-low, a=bit0).
  - 0..9 decoded; 10..15 -> blank.
  - Instantiated twice, for tens and ones.
- FSM, capture and blink counter live in the top.

Test Plan (bench uses CLK_HZ=8, BLINK_HZ=1, so blank_phase toggles every 4 cycles):
- Reset, then idle -> HEX1=HEX0=7'b1000000, HEX5=HEX4=7'b1111111, new_record=0.
- run rise, score=37, game_over pulse -> next cycle HEX1="3" 7'b0110000, HEX0="7" 7'b1111000, status "Lo", new_record=1. HEX1/HEX0 blank for cycles 5-8 after capture and reappear for cycles 9-12.
- New game (run rise clears blink/new_record); score=20, game_over -> hi_score stays 37, new_record=0, no blink. Repeat with score=37 -> still no record.
- New game; score=150 with win rising and game_over in the same cycle -> state WIN ("HI"), hi_score=99 (clamped), new_record=1.
- In PLAY, drop run with no event -> IDLE, status blank, hi_score unchanged. Pulse game_over while in IDLE -> no change.
- Assert reset asynchronously mid-blink, between clock edges -> outputs return to reset values before the next CLOCK_50 edge; hi_score=0.
